// File: rtl/seq_stream_ctrl_pkg.sv
// Package for the sequence-detector feed controller.
// Holds the FSM state type, the default parameter values, the pattern the
// downstream detector looks for, and a small width helper for counters.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } seq_ctrl_state_e;

    localparam int SEQ_DATA_W    = 8;
    localparam int SEQ_CNT_W     = 8;
    localparam int SEQ_DRAIN_CYC = 2;

    // Serial pattern recognised by the downstream detector.
    localparam logic [5:0] SEQ_PATTERN = 6'b101001;

    // Bits needed to hold a down-counter starting at n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_stream_ctrl_if.sv
// Producer-side valid/ready word interface of the feed controller.
//   in_valid : producer has a word
//   in_data  : word to serialize (DATA_W bits)
//   in_ready : controller takes in_data this cycle
// master = producer side, slave = controller side.
interface seq_stream_if
    import seq_ctrl_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/seq_stream_ctrl_det_counter.sv
// det_counter: counts rising edges of the detector's tone output.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous clear of det_count and irq (wins over an event)
//   tone      : detector output
//   thresh    : irq threshold, 0 disables irq
//   det_count : saturating count of tone rising edges (registered)
//   irq       : sticky, set when det_count steps onto thresh (registered)
module det_counter
    import seq_ctrl_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tone,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] det_count,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             tone_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q, irq_d;
    logic             tone_event;

    assign tone_event = tone && !tone_q;

    always_comb begin
        count_d = count_q;
        irq_d   = irq_q;
        if (clear) begin
            count_d = '0;
            irq_d   = 1'b0;
        end else if (tone_event && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
            // Only a real step onto thresh sets irq; sitting at saturation
            // produces no further steps, so irq fires once.
            if ((thresh != '0) && (count_d == thresh)) begin
                irq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_q  <= 1'b0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            tone_q  <= tone;
            count_q <= count_d;
            irq_q   <= irq_d;
        end
    end

    assign det_count = count_q;
    assign irq       = irq_q;

endmodule

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: accepts parallel words over valid/ready and serializes
// them MSB-first into the detector's stream input; counts tone pulses.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : permits acceptance of new words
//   clear        : synchronous clear of det_count / irq
//   in_if        : producer word interface (slave side)
//   stream_bit   : serialized bit (registered)
//   stream_valid : stream_bit is live (registered)
//   tone         : detector output
//   thresh       : irq threshold, 0 disables irq
//   det_count    : saturating detection count (registered)
//   irq          : sticky threshold interrupt (registered)
//   busy         : controller not in IDLE (registered)
module seq_stream_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int DATA_W    = SEQ_DATA_W,
    parameter int CNT_W     = SEQ_CNT_W,
    parameter int DRAIN_CYC = SEQ_DRAIN_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    seq_stream_if.slave      in_if,
    output logic             stream_bit,
    output logic             stream_valid,
    input  logic             tone,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] det_count,
    output logic             irq,
    output logic             busy
);

    localparam int BW = cnt_width(DATA_W);
    localparam int DW = cnt_width(DRAIN_CYC);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    seq_ctrl_state_e   state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic              stream_valid_q;
    logic              busy_q;
    logic              ready_c;
    logic              load_c;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ready_c     = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = enable;
            end
            SHIFT: begin
                // A new word may only enter on the last bit cycle, which is
                // what makes back-to-back words seamless.
                ready_c   = enable && (bit_cnt_q == '0);
                shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - BW'(1);
                if (bit_cnt_q == '0) begin
                    // Overridden below when a word is taken this cycle.
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LAST;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                shreg_d     = '0;
                bit_cnt_d   = '0;
                drain_cnt_d = '0;
            end
        endcase

        load_c = in_if.in_valid && ready_c;
        if (load_c) begin
            state_d   = SHIFT;
            shreg_d   = in_if.in_data;
            bit_cnt_d = BIT_LAST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            drain_cnt_q    <= '0;
            stream_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            stream_valid_q <= (state_d == SHIFT);
            busy_q         <= (state_d != IDLE);
        end
    end

    assign in_if.in_ready = ready_c;
    // shreg is cleared on leaving SHIFT, so the stream bit reads 0 when idle.
    assign stream_bit     = shreg_q[DATA_W-1];
    assign stream_valid   = stream_valid_q;
    assign busy           = busy_q;

    det_counter #(
        .CNT_W (CNT_W)
    ) u_det_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .tone      (tone),
        .thresh    (thresh),
        .det_count (det_count),
        .irq       (irq)
    );

endmodule

// File: doc/seq_stream_ctrl.md
# seq_stream_ctrl

Feed controller for the serial `101001` sequence detector. It accepts parallel words from an upstream producer over a valid/ready handshake and serializes them MSB-first into the detector's one-bit stream input. It also counts the detector's `tone` pulses in a saturating counter and raises a sticky interrupt when a programmable count threshold is reached. It sits between the bus-side producer and the detector datapath.

## Interface
- `DATA_W`, 8: width of each parallel word; must be ≥ 2.
- `CNT_W`, 8: width of the detection counter and of the threshold.
- `DRAIN_CYC`, 2: idle cycles held after the last bit so that detector latency settles; must be ≥ 1.

- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous active-high.
- `enable` input 1: permits acceptance of new words.
- `clear` input 1: synchronous clear of `det_count` and `irq`.
- `in_valid` input 1: producer has a word.
- `in_data` input DATA_W: word to serialize.
- `in_ready` output 1: controller accepts `in_data` this cycle.
- `stream_bit` output 1: serialized bit to the detector `Stream` pin.
- `stream_valid` output 1: `stream_bit` carries live data this cycle.
- `tone` input 1: detector output, high when a sequence is detected.
- `thresh` input CNT_W: interrupt threshold; 0 disables `irq`.
- `det_count` output CNT_W: saturating detection count.
- `irq` output 1: sticky; set when the threshold is reached.
- `busy` output 1: high in any state other than IDLE.

## Operation
- On reset, all outputs are 0, the state is IDLE, and the shift register, bit counter and `tone_q` are 0.
- **States:** IDLE, SHIFT, DRAIN.
- **IDLE**
  - `in_ready = enable`.
  - On `in_valid && in_ready`: load the shift register with `in_data`, set `bit_cnt = DATA_W-1`, go to SHIFT.
- **SHIFT**
  - Registered outputs: `stream_valid=1`, `stream_bit = shreg[DATA_W-1]`.
  - Each cycle: shift left by one and decrement `bit_cnt`.
  - `in_ready = enable && (bit_cnt == 0)`, so a new word is accepted only on the last bit cycle.
  - At `bit_cnt == 0` with handshake: reload and stay in SHIFT (zero-bubble back-to-back).
  - At `bit_cnt == 0` without handshake: go to DRAIN with `drain_cnt = DRAIN_CYC-1`.
- **DRAIN**
  - `stream_valid=0` and `stream_bit=0`; `in_ready=0`.
  - When `drain_cnt` reaches 0, go to IDLE.
- **`enable` dropped mid-word:** the current word completes all of its bits, then the controller enters DRAIN. No word is truncated.
- **Edge detection:** `tone_q` registers `tone`. A detection event is `tone && !tone_q`, evaluated in every state, including DRAIN.
- **Counter:**
  - On an event, `det_count` increments, saturating at 2^CNT_W−1.
  - `clear` has priority over an increment in the same cycle; the result is 0 and the event is lost.
- **irq:**
  - Set on the cycle in which `det_count` transitions to a value equal to `thresh`, provided `thresh != 0`.
  - Stays set until `clear` or `rst`.
  - Changing `thresh` never clears `irq`.
  - Saturation with `thresh = 2^CNT_W−1` sets `irq` exactly once.
- **Reset mid-operation:** immediate return to IDLE with all outputs 0. A partially shifted word is discarded.

## Timing
- **Accept to first bit:** a handshake at edge N makes `stream_valid=1` and the first bit (MSB) visible after edge N; the LSB follows DATA_W−1 cycles later.
- **Throughput:** one bit per cycle. Continuous words give `stream_valid` unbroken.
- **Single word:** `busy` is high for DATA_W + DRAIN_CYC cycles.
- **Count latency:** `det_count` and `irq` update one cycle after the cycle in which `tone` rises.
- **Registered outputs:** `stream_bit`, `stream_valid`, `det_count`, `irq` and `busy` are registered.
- **Combinational output:** `in_ready` is derived from state, `bit_cnt` and `enable` only; it never depends on `in_valid`.

## Structure
- **Package `seq_ctrl_pkg`:**
  - State enum `seq_ctrl_state_e` (IDLE, SHIFT, DRAIN).
  - Default constants `SEQ_DATA_W=8`, `SEQ_CNT_W=8`, `SEQ_DRAIN_CYC=2`.
  - Pattern constant `SEQ_PATTERN = 6'b101001`, shared with the bench model.
- **Sub-module `det_counter`:** tone edge detector, saturating counter, clear priority and irq logic.
- **Top module:** FSM and shifter only.

## Test plan
- **Single word with one match:** `enable=1`, one word `8'hA4` → stream `1,0,1,0,0,1,0,0` on 8 consecutive `stream_valid` cycles. The detector model pulses `tone` once; `det_count=1`; `busy` is high for 10 cycles.
- **Back-to-back words:** `8'hA4` then `8'h29` with `in_valid` held → 16 contiguous `stream_valid` cycles, with `in_ready` high only on cycles 8 and 16.
- **Threshold interrupt:** `thresh=3`, three `8'hA4` words → `irq` rises one cycle after the third tone and stays high. A subsequent `clear` gives `det_count=0`, `irq=0`.
- **Saturation and clear priority:** `CNT_W=2`, five detections → `det_count` sticks at 3. Asserting `clear` on the same cycle as a tone edge → `det_count=0`.
- **Enable dropped mid-word:** drop `enable` at bit 3 of `8'hFF` → all 8 bits still emitted, then DRAIN, then IDLE, with `in_ready=0` throughout.
- **Reset mid-operation:** assert `rst` at bit 4 → all outputs 0 immediately. After release, a new `8'hA4` serializes from its MSB.
